// File: rtl/shift_sequencer_if.sv
// Bundles the host command/status signals and the external lhs unit link of the shift sequencer.
// The slave modport is the sequencer. The master modport is the host together with the lhs unit.
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic             clear;
    logic [1:0]       cmd;
    logic [WIDTH-1:0] data_in;
    logic             carry_in;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic [1:0]       lhs_operation;
    logic [WIDTH-1:0] lhs_in;
    logic             lhs_carry_in;
    logic [WIDTH-1:0] lhs_out;
    logic             lhs_carry_out;

    modport master (
        output start, clear, cmd, data_in, carry_in, count, lhs_out, lhs_carry_out,
        input  busy, done, result, carry_out, lhs_operation, lhs_in, lhs_carry_in
    );

    modport slave (
        input  start, clear, cmd, data_in, carry_in, count, lhs_out, lhs_carry_out,
        output busy, done, result, carry_out, lhs_operation, lhs_in, lhs_carry_in
    );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-step shift/rotate sequencer. Each step is delegated to an external combinational
// lhs unit, and the accumulator and carry are fed back through that unit.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    shift_sequencer_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] LHS_PASS = 2'b00;
    localparam logic [1:0] LHS_ZERO = 2'b11;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] acc_r, acc_s;
    logic             c_r, c_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [1:0]       cmd_r, cmd_s;
    logic [1:0]       lhs_op_s;
    logic             lhs_cin_s;

    // Map a command to a shift direction. Bit 0 of cmd selects right (LSR/RRC) or left (LSL/RLC).
    function automatic logic [1:0] lhs_dir(input logic [1:0] op_cmd);
        return op_cmd[0] ? 2'b10 : 2'b01;
    endfunction

    // State register and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            acc_r   <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            cmd_r   <= 2'b00;
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            c_r     <= c_s;
            cnt_r   <= cnt_s;
            cmd_r   <= cmd_s;
        end
    end

    // Next-state, datapath update and lhs control. Clear overrides everything, including start.
    always_comb begin
        state_s   = state_r;
        acc_s     = acc_r;
        c_s       = c_r;
        cnt_s     = cnt_r;
        cmd_s     = cmd_r;
        lhs_op_s  = LHS_PASS;
        lhs_cin_s = 1'b0;
        if (bus.clear) begin
            lhs_op_s = LHS_ZERO;
            acc_s    = bus.lhs_out;
            c_s      = 1'b0;
            cnt_s    = {CNT_W{1'b0}};
            state_s  = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        acc_s   = bus.data_in;
                        c_s     = bus.carry_in;
                        cnt_s   = bus.count;
                        cmd_s   = bus.cmd;
                        state_s = (bus.count != {CNT_W{1'b0}}) ? ST_SHIFT : ST_DONE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // Rotates (cmd[1]=1) feed the carry back in. Logical shifts feed in zero.
                    lhs_op_s  = lhs_dir(cmd_r);
                    lhs_cin_s = cmd_r[1] ? c_r : 1'b0;
                    acc_s     = bus.lhs_out;
                    c_s       = bus.lhs_carry_out;
                    cnt_s     = cnt_r - CNT_W'(1);
                    state_s   = (cnt_r == CNT_W'(1)) ? ST_DONE : ST_SHIFT;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // While reset is held, the lhs controls are forced to pass, even if clear is high.
    assign bus.lhs_operation = reset ? lhs_op_s  : LHS_PASS;
    assign bus.lhs_carry_in  = reset ? lhs_cin_s : 1'b0;
    assign bus.lhs_in        = acc_r;
    assign bus.result        = acc_r;
    assign bus.carry_out     = c_r;
    assign bus.busy          = (state_r == ST_SHIFT);
    assign bus.done          = (state_r == ST_DONE);
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and random bench for shift_sequencer. It also supplies a behavioural lhs unit.
// Expected results are queued when a start is issued and popped when done appears.
module tb_shift_sequencer;
    typedef struct packed {
        logic [7:0] res;
        logic       c;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    shift_sequencer_if #(.WIDTH(8), .CNT_W(4)) bus ();

    shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural lhs unit: 01 shifts left and 10 shifts right, carry_in fills the vacated bit, 11 zeroes.
    always_comb begin
        bus.lhs_out       = bus.lhs_in;
        bus.lhs_carry_out = bus.lhs_carry_in;
        case (bus.lhs_operation)
            2'b01: begin
                bus.lhs_out       = {bus.lhs_in[6:0], bus.lhs_carry_in};
                bus.lhs_carry_out = bus.lhs_in[7];
            end
            2'b10: begin
                bus.lhs_out       = {bus.lhs_carry_in, bus.lhs_in[7:1]};
                bus.lhs_carry_out = bus.lhs_in[0];
            end
            2'b11: begin
                bus.lhs_out       = 8'h00;
                bus.lhs_carry_out = 1'b0;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Command-level reference: the carry always receives the bit shifted out.
    function automatic exp_t ref_model(input logic [1:0] c, input logic [7:0] d,
                                       input logic ci, input int n);
        logic [7:0] a;
        logic       cy;
        a  = d;
        cy = ci;
        for (int k = 0; k < n; k++) begin
            case (c)
                2'b00:   {cy, a} = {a, 1'b0};
                2'b01:   {a, cy} = {1'b0, a};
                2'b10:   {cy, a} = {a, cy};
                default: {a, cy} = {cy, a};
            endcase
        end
        return '{res: a, c: cy};
    endfunction

    // Call between clock edges. Start is sampled on the next rising edge (T0).
    // Afterwards the inputs are scrambled, which the running sequence must ignore.
    task automatic do_start(input logic [1:0] c, input logic [7:0] d, input logic ci,
                            input logic [3:0] n, input exp_t e);
        bus.start    = 1'b1;
        bus.cmd      = c;
        bus.data_in  = d;
        bus.carry_in = ci;
        bus.count    = n;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.cmd      = ~c;
        bus.data_in  = ~d;
        bus.carry_in = ~ci;
        bus.count    = n + 4'd3;
    endtask

    task automatic wait_done(input string tag, input logic [1:0] c, input int n, input bit inject);
        int   cycles;
        int   busy_cnt;
        exp_t e;
        cycles   = 0;
        busy_cnt = 0;
        @(negedge clk);
        while (bus.done !== 1'b1 && cycles < 40) begin
            if (bus.busy === 1'b1) begin
                busy_cnt++;
                check({tag, "_lhs_op"}, bus.lhs_operation, c[0] ? 2'b10 : 2'b01);
            end
            if (inject && cycles == 2) begin
                bus.start   = 1'b1;
                bus.cmd     = 2'b00;
                bus.data_in = 8'hFF;
                bus.count   = 4'd1;
            end else begin
                bus.start = 1'b0;
            end
            cycles++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, "_done_seen"}, (cycles < 40), 1'b1);
        check({tag, "_latency"}, cycles, n);
        check({tag, "_busy_cycles"}, busy_cnt, n);
        if (n == 0) check({tag, "_lhs_op_zero_cnt"}, bus.lhs_operation, 2'b00);
        e = sb_q.pop_front();
        check({tag, "_result"}, bus.result, e.res);
        check({tag, "_carry"}, bus.carry_out, e.c);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, bus.done, 1'b0);
        check({tag, "_busy_after"}, bus.busy, 1'b0);
        check({tag, "_hold_result"}, bus.result, e.res);
    endtask

    initial begin
        exp_t e;
        bit   any_done;
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.clear    = 1'b0;
        bus.cmd      = 2'b00;
        bus.data_in  = 8'h00;
        bus.carry_in = 1'b0;
        bus.count    = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_result", bus.result, 8'h00);
        check("rst_carry", bus.carry_out, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_lhs_op", bus.lhs_operation, 2'b00);
        check("rst_lhs_cin", bus.lhs_carry_in, 1'b0);
        reset = 1'b1;

        do_start(2'b00, 8'hAA, 1'b0, 4'd1, '{res: 8'h54, c: 1'b1});
        wait_done("lsl_aa", 2'b00, 1, 1'b0);
        do_start(2'b11, 8'h55, 1'b1, 4'd1, '{res: 8'hAA, c: 1'b1});
        wait_done("rrc_55", 2'b11, 1, 1'b0);
        do_start(2'b10, 8'h01, 1'b0, 4'd9, '{res: 8'h01, c: 1'b0});
        wait_done("rlc_ring", 2'b10, 9, 1'b0);
        // The start pulsed mid-sequence here must be ignored.
        do_start(2'b01, 8'h80, 1'b0, 4'd8, '{res: 8'h00, c: 1'b1});
        wait_done("lsr_80", 2'b01, 8, 1'b1);
        do_start(2'b11, 8'h3C, 1'b1, 4'd0, '{res: 8'h3C, c: 1'b1});
        wait_done("cnt_zero", 2'b11, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            logic [1:0] rc;
            logic [7:0] rd;
            logic       rci;
            logic [3:0] rn;
            rc  = 2'($urandom_range(0, 3));
            rd  = 8'($urandom);
            rci = 1'($urandom_range(0, 1));
            rn  = 4'($urandom_range(0, 15));
            do_start(rc, rd, rci, rn, ref_model(rc, rd, rci, int'(rn)));
            wait_done("rand", rc, int'(rn), 1'b0);
        end

        // Clear after two steps. Clear also wins over a simultaneous start.
        do_start(2'b00, 8'hFF, 1'b0, 4'd5, '{res: 8'h00, c: 1'b0});
        repeat (3) @(negedge clk);
        check("clr_two_steps", bus.result, 8'hFC);
        bus.clear   = 1'b1;
        bus.start   = 1'b1;
        bus.data_in = 8'h77;
        bus.count   = 4'd3;
        #1;
        check("clr_lhs_op", bus.lhs_operation, 2'b11);
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        e = sb_q.pop_front();
        check("clr_result", bus.result, e.res);
        check("clr_carry", bus.carry_out, e.c);
        check("clr_busy", bus.busy, 1'b0);
        any_done = bus.done;
        repeat (4) begin
            @(negedge clk);
            any_done = any_done | bus.done;
        end
        check("clr_no_done", any_done, 1'b0);

        // Asynchronous reset mid-sequence.
        do_start(2'b00, 8'hFF, 1'b0, 4'd5, '{res: 8'h00, c: 1'b0});
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        e = sb_q.pop_front();
        check("arst_result", bus.result, e.res);
        check("arst_carry", bus.carry_out, e.c);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_done", bus.done, 1'b0);
        check("arst_lhs_op", bus.lhs_operation, 2'b00);
        any_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            any_done = any_done | bus.done;
        end
        check("arst_no_done", any_done, 1'b0);
        reset = 1'b1;
        do_start(2'b10, 8'h81, 1'b1, 4'd2, ref_model(2'b10, 8'h81, 1'b1, 2));
        wait_done("post_rst", 2'b10, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The parameters SHALL be:
- WIDTH, default 8, data width in bits.
- CNT_W, default 4, shift-count width in bits.

REQ-002 The ports SHALL be as listed below (name, direction, width, meaning).
- clk, in, 1: single clock; all state changes on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- start, in, 1: request a shift sequence.
- clear, in, 1: request a zero operation or abort.
- cmd, in, 2: 00 LSL, 01 LSR, 10 RLC (rotate left through carry), 11 RRC (rotate right through carry).
- data_in, in, WIDTH: operand.
- carry_in, in, 1: initial carry.
- count, in, CNT_W: number of single-bit steps, 0..2^CNT_W-1.
- busy, out, 1: a sequence is in progress.
- done, out, 1: one-cycle completion pulse.
- result, out, WIDTH: accumulator value.
- carry_out, out, 1: carry flag.
- lhs_operation, out, 2: to the lhs unit; 00 pass, 01 shift left, 10 shift right, 11 zero.
- lhs_in, out, WIDTH: to the lhs unit; always equal to the accumulator.
- lhs_carry_in, out, 1: to the lhs unit.
- lhs_out, in, WIDTH: from the lhs unit; combinational, valid in the same cycle.
- lhs_carry_out, in, 1: from the lhs unit; combinational, valid in the same cycle.

Function
REQ-003 The block SHALL hold an accumulator register acc[WIDTH-1:0], a carry flag c, a down-counter cnt[CNT_W-1:0], a latched cmd, and FSM states IDLE, SHIFT and DONE.

REQ-004 The data outputs SHALL be driven as follows:
- result = acc.
- carry_out = c.
- lhs_in = acc.
- busy = 1 only in SHIFT.
- done = 1 only in DONE.

REQ-005 The lhs controls SHALL be driven as follows:
- In IDLE and DONE: lhs_operation = 00 and lhs_carry_in = 0, except while clear is applied.
- In SHIFT: lhs_operation = 01 for LSL/RLC and 10 for LSR/RRC.
- In SHIFT: lhs_carry_in = c for RLC/RRC and 0 for LSL/LSR.

REQ-006 Start acceptance SHALL be as follows:
- In IDLE or DONE, with start=1 and clear=0, the rising edge SHALL load acc<=data_in, c<=carry_in, cnt<=count, and latch cmd.
- Next state SHALL be SHIFT if count!=0, else DONE.

REQ-007 Each SHIFT-state edge SHALL update acc<=lhs_out, c<=lhs_carry_out and cnt<=cnt-1; the FSM SHALL go to DONE when cnt==1, else stay in SHIFT.

REQ-008 Latency: for a start sampled at edge T0 with count=N, acc SHALL update at edges T1..TN and done SHALL be high for exactly the cycle between edges TN and TN+1.

REQ-009 For count=0, done SHALL be high in the cycle after T0, with result=data_in and carry_out=carry_in.

REQ-010 DONE SHALL last one cycle and then go to IDLE, unless a start is accepted per REQ-006.

REQ-011 acc and c SHALL hold their values in IDLE and DONE until the next start or clear.

REQ-012 start SHALL be ignored while busy=1.

REQ-013 Clear SHALL behave as follows:
- clear=1 in any state SHALL drive lhs_operation=11 in that cycle.
- The edge SHALL load acc<=lhs_out (0) and c<=0, and set the next state to IDLE.
- No done pulse SHALL be generated, including when clear aborts a SHIFT sequence.

REQ-014 clear SHALL take priority over start in the same cycle.

REQ-015 cmd, data_in, carry_in and count changes while busy=1 SHALL have no effect on the running sequence.

REQ-016 The carry flag SHALL record the last bit shifted out for all commands; for LSL/LSR the shifted-in bit SHALL be 0.

Reset
REQ-017 reset=0 SHALL immediately, without waiting for clk, force: state IDLE, acc=0, c=0, cnt=0, busy=0, done=0, lhs_operation=00, lhs_carry_in=0.

REQ-018 A reset asserted mid-sequence SHALL abort it with no done pulse.

REQ-019 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-020 LSL, data_in=0xAA, carry_in=0, count=1 -> done 1 cycle after start; result=0x54; carry_out=1.

REQ-021 RRC, data_in=0x55, carry_in=1, count=1 -> result=0xAA; carry_out=1.

REQ-022 RLC, data_in=0x01, carry_in=0, count=9 -> busy high 9 cycles; result=0x01; carry_out=0 (full 9-bit ring rotation).

REQ-023 LSR, data_in=0x80, carry_in=0, count=8 -> done 8 cycles after start; result=0x00; carry_out=1.

REQ-024 count=0, data_in=0x3C, carry_in=1 -> done the next cycle; result=0x3C; carry_out=1; lhs_operation never leaves 00.

REQ-025 LSL, data_in=0xFF, count=5: assert clear after 2 steps -> result=0x00, carry_out=0, no done pulse.
- Repeat with reset=0 instead of clear -> outputs 0 immediately, no done pulse.
- start applied during SHIFT -> ignored.
